// File: rtl/mult_issue_seq.sv
// mult_issue_seq: FIFO-buffered issue stage for a sequential multiplier, one operation in flight
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   in_valid     operand pair offered         in_ready     FIFO not full
//   in_a/in_b    operands pushed into FIFO
//   mult_load    load strobe to multiplier    mult_a/b     operands held from pop to next pop
//   mult_product multiplier result, sampled at the end of the wait window
//   out_valid    out_product holds a result   out_ready    consumer accepts result
//   out_product  captured 2*WIDTH product
//   busy         FSM not in IDLE              fifo_count   occupied FIFO entries
module mult_issue_seq #(
    parameter int WIDTH       = 6,
    parameter int DEPTH       = 4,
    parameter int LOAD_CYCLES = 1,
    parameter int MULT_CYCLES = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    output logic                     mult_load,
    output logic [WIDTH-1:0]         mult_a,
    output logic [WIDTH-1:0]         mult_b,
    input  logic [2*WIDTH-1:0]       mult_product,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*WIDTH-1:0]       out_product,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CMAX = LOAD_CYCLES > MULT_CYCLES ? LOAD_CYCLES : MULT_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, HOLD} state_t;

    state_t              state, next_state;
    logic [2*WIDTH-1:0]  mem [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       cnt;
    logic                push, pop, capture;

    assign in_ready = fifo_count != (AW+1)'(DEPTH);
    assign push     = in_valid && in_ready;
    assign busy     = state != IDLE;

    // pop looks only at the registered count, so a pair pushed this cycle cannot issue until next cycle
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        capture    = 1'b0;
        mult_load  = 1'b0;
        case (state)
            IDLE: begin
                pop        = fifo_count != '0;
                next_state = pop ? LOAD : IDLE;
            end
            LOAD: begin
                mult_load  = 1'b1;
                next_state = cnt == CW'(LOAD_CYCLES - 1) ? WAIT : LOAD;
            end
            WAIT: begin
                capture    = cnt == CW'(MULT_CYCLES - 1);
                next_state = capture ? HOLD : WAIT;
            end
            HOLD:    next_state = (out_valid && out_ready) ? IDLE : HOLD;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // phase counter restarts on every state change
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= '0;
        else      cnt <= (next_state != state) ? '0 : cnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_a, in_b};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            wr_ptr     <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr     <= pop ? rd_ptr + AW'(1) : rd_ptr;
            fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mult_a      <= '0;
            mult_b      <= '0;
            out_valid   <= 1'b0;
            out_product <= '0;
        end else begin
            if (pop) {mult_a, mult_b} <= mem[rd_ptr];
            if (capture) begin
                out_valid   <= 1'b1;
                out_product <= mult_product;
            end else if (state == HOLD && out_ready) begin
                out_valid   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mult_issue_seq.sv
// tb_mult_issue_seq: directed stimulus with a per-cycle behavioural model and literal product checks
module tb_mult_issue_seq;
    localparam int W  = 6;
    localparam int D  = 4;
    localparam int LC = 1;
    localparam int MC = 8;

    logic           clk = 0, rst = 0, in_valid = 0, out_ready = 0;
    logic [W-1:0]   in_a = 0, in_b = 0;
    logic           in_ready, mult_load, out_valid, busy;
    logic [W-1:0]   mult_a, mult_b;
    logic [2*W-1:0] mult_product, out_product;
    logic [2:0]     fifo_count;

    always #5 clk = ~clk;

    mult_issue_seq #(.WIDTH(W), .DEPTH(D), .LOAD_CYCLES(LC), .MULT_CYCLES(MC)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mult_load(mult_load), .mult_a(mult_a), .mult_b(mult_b), .mult_product(mult_product),
        .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product), .busy(busy),
        .fifo_count(fifo_count)
    );

    // multiplier stand-in: result is only correct from the MC-th cycle after load drops
    logic [2*W-1:0] cap = 0;
    int             k = 1000;
    always @(posedge clk) begin
        if (mult_load) begin
            cap <= 12'(mult_a) * 12'(mult_b);
            k   <= 0;
        end else if (k < 1000) k <= k + 1;
    end
    assign mult_product = (k >= MC - 1) ? cap : ~cap;

    int n_cmp = 0, n_err = 0, cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // behavioural model: a queue of pending pairs plus the age of the one in flight
    typedef struct {int a; int b;} pr_t;
    pr_t q[$];
    int  cur_a = 0, cur_b = 0, age = 0;
    bit  infl = 0;

    function automatic bit m_load();
        return infl && age <= LC;
    endfunction
    function automatic bit m_valid();
        return infl && age >= 1 + LC + MC;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            infl  = 0;
            age   = 0;
            cur_a = 0;
            cur_b = 0;
        end else begin
            bit pu, po, hs;
            pu = in_valid && (q.size() != D);
            po = !infl && q.size() > 0;
            hs = m_valid() && out_ready;
            if (infl) age++;
            if (hs) infl = 0;
            if (po) begin
                cur_a = q[0].a;
                cur_b = q[0].b;
                void'(q.pop_front());
                infl = 1;
                age  = 1;
            end
            if (pu) q.push_back('{int'(in_a), int'(in_b)});
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    int  got[$];
    int  n_loads = 0, load_rise = 0, load_len = 0, load_a = 0, load_b = 0, valid_rise = 0;
    bit  prev_load = 0, prev_valid = 0;

    always @(negedge clk) begin
        chk("in_ready", in_ready, q.size() != D);
        chk("fifo_count", fifo_count, q.size());
        chk("busy", busy, infl);
        chk("mult_load", mult_load, m_load());
        chk("mult_a", mult_a, cur_a);
        chk("mult_b", mult_b, cur_b);
        chk("out_valid", out_valid, m_valid());
        if (m_valid()) chk("out_product", out_product, cur_a * cur_b);
        if (mult_load && !prev_load) begin
            n_loads++;
            load_rise = cyc;
            load_len  = 0;
            load_a    = mult_a;
            load_b    = mult_b;
        end
        if (mult_load) load_len++;
        if (out_valid && !prev_valid) valid_rise = cyc;
        if (out_valid && out_ready) got.push_back(int'(out_product));
        prev_load  = mult_load;
        prev_valid = out_valid;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int a, input int b);
        bit acc = 0;
        in_a     = W'(a);
        in_b     = W'(b);
        in_valid = 1;
        for (int i = 0; i < 500 && !acc; i++) begin
            acc = in_ready;
            tick();
        end
        in_valid = 0;
        chk("push_accepted", acc, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (!busy && fifo_count == 0 && !out_valid) break;
            tick();
        end
        chk("idle_reached", busy || fifo_count != 0 || out_valid, 0);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 100; i++) begin
            if (out_valid) break;
            tick();
        end
        chk("valid_reached", out_valid, 1);
    endtask

    task automatic reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_fifo_count"}, fifo_count, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_mult_load"}, mult_load, 0);
        chk({tag, "_mult_ab"}, {mult_a, mult_b}, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_product"}, out_product, 0);
    endtask

    int e2[3] = '{132, 0, 3906};
    int e3[6] = '{2, 12, 30, 56, 90, 143};
    int e6[9] = '{6, 20, 42, 72, 110, 156, 210, 3969, 0};

    initial begin
        int base, nl;
        tick();
        tick();
        reset_outputs("rst0");
        rst       = 1;
        out_ready = 1;
        tick();

        base = got.size();
        nl   = n_loads;
        push(57, 32);
        wait_idle();
        chk("t1_count", got.size() - base, 1);
        chk("t1_prod", got[base], 1824);
        chk("t1_loads", n_loads - nl, 1);
        chk("t1_load_len", load_len, 1);
        chk("t1_mult_a", load_a, 57);
        chk("t1_mult_b", load_b, 32);
        chk("t1_latency", valid_rise - (load_rise - 1), 10);

        base = got.size();
        nl   = n_loads;
        push(11, 12);
        push(17, 0);
        push(63, 62);
        wait_idle();
        chk("t2_count", got.size() - base, 3);
        for (int i = 0; i < 3; i++) chk($sformatf("t2_prod%0d", i), got[base + i], e2[i]);
        chk("t2_loads", n_loads - nl, 3);

        out_ready = 0;
        base      = got.size();
        push(1, 2);
        push(3, 4);
        push(5, 6);
        push(7, 8);
        push(9, 10);
        fork
            push(11, 13);
            begin
                int nl2;
                chk("t3_full_count", fifo_count, 4);
                chk("t3_full_ready", in_ready, 0);
                wait_valid();
                chk("t3_stalled", in_ready, 0);
                nl2 = n_loads;
                repeat (20) tick();
                chk("t4_valid", out_valid, 1);
                chk("t4_prod", out_product, 2);
                chk("t4_no_load", n_loads - nl2, 0);
                chk("t4_count", fifo_count, 4);
                out_ready = 1;
            end
        join
        wait_idle();
        chk("t3_count", got.size() - base, 6);
        for (int i = 0; i < 6; i++) chk($sformatf("t3_prod%0d", i), got[base + i], e3[i]);

        push(3, 3);
        push(4, 4);
        push(2, 2);
        repeat (3) tick();
        chk("t5_in_wait", busy && !mult_load && !out_valid, 1);
        chk("t5_queued", fifo_count, 2);
        rst = 0;
        #1;
        reset_outputs("t5_rst");
        base = got.size();
        tick();
        reset_outputs("t5_held");
        rst = 1;
        tick();
        push(5, 5);
        wait_idle();
        chk("t5_count", got.size() - base, 1);
        chk("t5_prod", got[base], 25);

        out_ready = 0;
        base      = got.size();
        push(2, 3);
        push(4, 5);
        push(6, 7);
        wait_valid();
        out_ready = 1;
        tick();
        out_ready = 0;
        chk("t6_pre_count", fifo_count, 2);
        chk("t6_pre_idle", busy, 0);
        in_a     = 8;
        in_b     = 9;
        in_valid = 1;
        tick();
        in_valid = 0;
        chk("t6_same_cycle", fifo_count, 2);
        chk("t6_issued", busy, 1);
        out_ready = 1;
        push(10, 11);
        push(12, 13);
        push(14, 15);
        push(63, 63);
        push(0, 63);
        wait_idle();
        chk("t6_count", got.size() - base, 9);
        for (int i = 0; i < 9; i++) chk($sformatf("t6_prod%0d", i), got[base + i], e6[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d results", got.size());
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end
endmodule
